// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the 3x3 array result vector on a done rise
// and streams the nine words over valid/ready, flagging dropped frames.
module systolic_result_drain #(
  parameter int N_OUT  = 9,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_OUT-1:0][DATA_W-1:0]  out,
  input  logic                          done,
  output logic [DATA_W-1:0]             m_data,
  output logic [IDX_W-1:0]              m_idx,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [7:0]                    frame_cnt
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);
  state_t                         state_q, state_d;
  logic                           done_q;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [N_OUT-1:0][DATA_W-1:0]   buf_q, buf_d;
  logic                           overrun_q, overrun_d;
  logic [7:0]                     frame_cnt_q, frame_cnt_d;
  logic                           done_rise, xfer, last_xfer, load, drop;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // A final-word transfer frees the buffer in the same cycle, so a coinciding
  // rise reloads it instead of being dropped.
  always_comb begin
    done_rise = done & ~done_q;
    xfer      = (state_q == STREAM) & m_ready;
    last_xfer = xfer & (idx_q == LAST);
    load      = done_rise & ((state_q == IDLE) | last_xfer);
    drop      = done_rise & ~load;
    state_d   = load ? STREAM : last_xfer ? IDLE : state_q;
  end
  always_comb begin
    m_valid   = state_q == STREAM;
    busy      = state_q == STREAM;
    m_data    = (state_q == STREAM) ? buf_q[idx_q] : '0;
    m_idx     = idx_q;
    m_last    = (state_q == STREAM) & (idx_q == LAST);
    overrun   = overrun_q;
    frame_cnt = frame_cnt_q;
  end
  always_comb begin
    idx_d       = load ? '0 : xfer ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) : idx_q;
    buf_d       = load ? out : buf_q;
    overrun_d   = drop | (overrun_q & ~clr_overrun);
    frame_cnt_d = frame_cnt_q + {7'd0, last_xfer};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done_q      <= 1'b0;
      idx_q       <= '0;
      buf_q       <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q      <= done;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: directed scenarios for the result drain.
module tb_systolic_result_drain;
  logic              clk = 1'b0;
  logic              rst;
  logic [8:0][31:0]  out_v;
  logic              done, m_ready, clr_overrun;
  logic [31:0]       m_data;
  logic [3:0]        m_idx;
  logic              m_last, m_valid, busy, overrun;
  logic [7:0]        frame_cnt;
  int                pass_cnt = 0;
  int                total = 0;
  logic [7:0]        exp_fc = 8'd0;

  systolic_result_drain dut (
    .clk(clk), .rst(rst), .out(out_v), .done(done),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .overrun(overrun),
    .clr_overrun(clr_overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_out(input int base);
    for (int i = 0; i < 9; i++) out_v[i] = 32'(base + i);
  endtask

  task automatic test_reset;
    rst = 1'b1; done = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0; out_v = '0;
    step();
    total++;
    if ({m_valid, m_data, m_idx, m_last, busy, overrun, frame_cnt} !== 47'd0)
      $display("FAIL reset_outputs got v=%b d=%h i=%0d l=%b b=%b o=%b fc=%0d want all zero",
               m_valid, m_data, m_idx, m_last, busy, overrun, frame_cnt);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total++;
    if (m_valid !== 1'b0) $display("FAIL idle_after_reset got m_valid=%b want 0", m_valid);
    else pass_cnt++;
  endtask

  task automatic test_single;
    int extra_valid;
    set_out(100); m_ready = 1'b1; done = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      total++;
      if ({m_valid, busy, m_idx, m_data, m_last} !== {1'b1, 1'b1, 4'(i), 32'(100 + i), i == 8})
        $display("FAIL single_word%0d got v=%b b=%b i=%0d d=%0d l=%b want v=1 b=1 i=%0d d=%0d l=%b",
                 i, m_valid, busy, m_idx, m_data, m_last, i, 100 + i, i == 8);
      else pass_cnt++;
      step();
    end
    exp_fc++;
    total++;
    if ({m_valid, busy, frame_cnt} !== {2'b00, exp_fc})
      $display("FAIL single_end got v=%b b=%b fc=%0d want v=0 b=0 fc=%0d", m_valid, busy, frame_cnt, exp_fc);
    else pass_cnt++;
    extra_valid = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_valid) extra_valid++;
      step();
    end
    total++;
    if (extra_valid !== 0 || frame_cnt !== exp_fc)
      $display("FAIL single_held_done got extra_valid=%0d fc=%0d want 0 and fc=%0d", extra_valid, frame_cnt, exp_fc);
    else pass_cnt++;
    done = 1'b0;
    step();
  endtask

  task automatic test_backpressure;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int w, c, bad;
    set_out(100); m_ready = 1'b0; done = 1'b1;
    step();
    done = 1'b0;
    w = 0; c = 0; bad = 0;
    while (w < 9 && c < 100) begin
      m_ready = pat[c % 6];
      if ({m_valid, m_idx, m_data} !== {1'b1, 4'(w), 32'(100 + w)}) begin
        bad++;
        $display("FAIL bp_cycle%0d got v=%b i=%0d d=%0d want v=1 i=%0d d=%0d",
                 c, m_valid, m_idx, m_data, w, 100 + w);
      end
      step();
      if (m_ready) w++;
      c++;
    end
    total++;
    if (bad !== 0 || w !== 9) $display("FAIL bp_stream got bad=%0d words=%0d want 0 and 9", bad, w);
    else pass_cnt++;
    exp_fc++;
    total++;
    if ({m_valid, frame_cnt} !== {1'b0, exp_fc})
      $display("FAIL bp_end got v=%b fc=%0d want v=0 fc=%0d", m_valid, frame_cnt, exp_fc);
    else pass_cnt++;
  endtask

  task automatic test_snapshot;
    int bad;
    set_out(100); m_ready = 1'b1; done = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) out_v = {9{32'hDEADBEEF}};
      if (m_data !== 32'(100 + i) || m_idx !== 4'(i)) begin
        bad++;
        $display("FAIL snap_word%0d got d=%h i=%0d want d=%0d", i, m_data, m_idx, 100 + i);
      end
      step();
    end
    total++;
    if (bad !== 0) $display("FAIL snapshot got bad=%0d want 0", bad);
    else pass_cnt++;
    exp_fc++;
    done = 1'b0;
    step();
  endtask

  task automatic test_overrun;
    int bad;
    set_out(100); m_ready = 1'b1; done = 1'b1;
    step();
    done = 1'b0;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin done = 1'b1; set_out(300); end
      if (m_data !== 32'(100 + i) || m_idx !== 4'(i)) begin
        bad++;
        $display("FAIL ovr_word%0d got d=%0d i=%0d want d=%0d", i, m_data, m_idx, 100 + i);
      end
      if (i == 4) begin
        total++;
        if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun);
        else pass_cnt++;
      end
      step();
    end
    total++;
    if (bad !== 0) $display("FAIL overrun_words got bad=%0d want 0", bad);
    else pass_cnt++;
    exp_fc++;
    total++;
    if ({m_valid, overrun, frame_cnt} !== {2'b01, exp_fc})
      $display("FAIL overrun_end got v=%b o=%b fc=%0d want v=0 o=1 fc=%0d", m_valid, overrun, frame_cnt, exp_fc);
    else pass_cnt++;
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun);
    else pass_cnt++;
    done = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    int bad;
    set_out(100); m_ready = 1'b1; done = 1'b1;
    step();
    done = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++;
    if ({m_valid, m_idx, m_data, m_last} !== {1'b1, 4'd8, 32'd108, 1'b1})
      $display("FAIL b2b_word8 got v=%b i=%0d d=%0d l=%b want v=1 i=8 d=108 l=1", m_valid, m_idx, m_data, m_last);
    else pass_cnt++;
    done = 1'b1; set_out(200);
    step();
    exp_fc++;
    total++;
    if ({m_valid, m_idx, m_data, overrun, frame_cnt} !== {1'b1, 4'd0, 32'd200, 1'b0, exp_fc})
      $display("FAIL b2b_reload got v=%b i=%0d d=%0d o=%b fc=%0d want v=1 i=0 d=200 o=0 fc=%0d",
               m_valid, m_idx, m_data, overrun, frame_cnt, exp_fc);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if ({m_valid, m_idx, m_data} !== {1'b1, 4'(i), 32'(200 + i)}) begin
        bad++;
        $display("FAIL b2b_word%0d got v=%b i=%0d d=%0d want d=%0d", i, m_valid, m_idx, m_data, 200 + i);
      end
      step();
    end
    exp_fc++;
    total++;
    if (bad !== 0 || {m_valid, frame_cnt} !== {1'b0, exp_fc})
      $display("FAIL b2b_second got bad=%0d v=%b fc=%0d want 0, v=0, fc=%0d", bad, m_valid, frame_cnt, exp_fc);
    else pass_cnt++;
    done = 1'b0;
    step();
  endtask

  task automatic test_reset_midstream;
    set_out(100); m_ready = 1'b1; done = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    total++;
    if (m_idx !== 4'd5) $display("FAIL rst_pre_idx got %0d want 5", m_idx);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({m_valid, m_data, m_idx, m_last, busy, overrun, frame_cnt} !== 47'd0)
      $display("FAIL rst_async got v=%b d=%h i=%0d l=%b b=%b o=%b fc=%0d want all zero",
               m_valid, m_data, m_idx, m_last, busy, overrun, frame_cnt);
    else pass_cnt++;
    step();
    rst = 1'b0;
    exp_fc = 8'd0;
    total++;
    if (m_valid !== 1'b0) $display("FAIL rst_release_idle got v=%b want 0", m_valid);
    else pass_cnt++;
    step();
    total++;
    if ({m_valid, m_idx, m_data, frame_cnt} !== {1'b1, 4'd0, 32'd100, 8'd0})
      $display("FAIL rst_restart got v=%b i=%0d d=%0d fc=%0d want v=1 i=0 d=100 fc=0", m_valid, m_idx, m_data, frame_cnt);
    else pass_cnt++;
    for (int i = 0; i < 9; i++) step();
    exp_fc++;
    total++;
    if ({m_valid, frame_cnt} !== {1'b0, exp_fc})
      $display("FAIL rst_frame_done got v=%b fc=%0d want v=0 fc=%0d", m_valid, frame_cnt, exp_fc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_snapshot();
    test_overrun();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
